imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader for the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake, packs the bytes into 32-bit big-endian words, and writes them into instruction memory through a dedicated write port. Instruction memory otherwise only ever sees reads from the processor. The processor is held stopped (`cpu_run` low) until a complete, valid image has been written.

## Interface
- `DEPTH`, 64: instruction memory size in words; largest legal image length.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load session; honoured only in IDLE, DONE, ERR.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader can accept a byte; a transfer occurs when `rx_valid & rx_ready` at a rising edge.
- `im_we`  out  1  instruction memory write strobe, one cycle per word.
- `im_addr`  out  32  byte address of the word being written (word index × 4).
- `im_wdata`  out  32  word being written.
- `cpu_run`  out  1  high means processor may run; low holds it.
- `busy`  out  1  session in progress (LEN_HI, LEN_LO, DATA).
- `done`  out  1  last session completed successfully.
- `error`  out  1  last session rejected (length > DEPTH).
- `word_cnt`  out  16  words written in the current or last session.

## Operation
- Stream format:
  - 2-byte word count N, high byte first.
  - Then 4·N data bytes.
  - First data byte of each word lands in [31:24], last in [7:0].
- States: IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR.
- IDLE: `rx_ready`=0. `start` → LEN_HI.
- LEN_HI: `rx_ready`=1. Accepted byte → len[15:8]; → LEN_LO.
- LEN_LO: `rx_ready`=1. Accepted byte → len[7:0]. Then:
  - N==0 → DONE.
  - N>DEPTH → ERR.
  - else → DATA.
- DATA:
  - `rx_ready`=1 until the final byte of the image is accepted.
  - 2-bit byte counter selects the byte lane; a word register holds the partial word.
  - On acceptance of byte 3 of word i: for the following cycle, `im_we`=1, `im_addr`=4·i, `im_wdata`=assembled word, and `word_cnt` increments.
  - Bytes of word i+1 may be accepted during that write cycle.
  - After the final byte: `rx_ready`=0. The state moves to DONE on the edge that ends the final write cycle.
- DONE: `done`=1, `cpu_run`=1, `rx_ready`=0. `start` → LEN_HI, and `cpu_run`, `done`, `word_cnt` clear on that edge.
- ERR: `error`=1, `cpu_run`=0, `rx_ready`=0. `start` → LEN_HI, and `error` clears.
- `start` while `busy` is ignored.
- `rx_valid` while `rx_ready`=0 is ignored; no byte is consumed.
- Memory contents are never cleared by this block. Words beyond N keep their previous values.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - state IDLE.
  - `rx_ready`, `im_we`, `cpu_run`, `busy`, `done`, `error` = 0.
  - `im_addr`, `im_wdata`, `word_cnt` = 0.
- Throughput: one byte per cycle when `rx_valid` is held high. Gaps in `rx_valid` stall the byte counter without side effects.
- Byte-3 acceptance at edge k ⇒ `im_we` high from edge k to edge k+1 exactly. `im_addr`/`im_wdata` are stable through that cycle.
- Final write at cycle k..k+1 ⇒ `done` and `cpu_run` rise at edge k+1. `cpu_run` never overlaps an `im_we` pulse.
- Minimum session: `start` at edge s, then 2 + 4·N accepted bytes. `done` rises 1 cycle after the last byte is accepted.
- N==0: `done` rises on the edge accepting the length low byte. No `im_we`.
- Reset mid-session: immediate return to reset values. A partially written image stays in memory but `cpu_run` stays 0.
- `im_addr` bits [1:0] are always 0. Address range is 0 to 4·(DEPTH−1).

## Test plan
- Reset: hold `rst`=0 with random inputs → every output 0, `rx_ready`=0, no `im_we`.
- Two-word load, continuous valid: `start`, then bytes 00 02 20 08 00 05 AC 08 00 00 → `im_we` pulses (addr 0, 0x20080005) and (addr 4, 0xAC080000). `word_cnt`=2. `done`/`cpu_run` rise the cycle after the second pulse.
- Same stream with random `rx_valid` gaps → identical writes, no duplicate or missing pulses, `rx_ready` drops after the last byte.
- Length 0 → `done`=1, no `im_we`. Length 0x0041 with DEPTH=64 → `error`=1, `cpu_run`=0, `rx_ready`=0. Next `start` clears `error`.
- Reset asserted after 5 data bytes of a 3-word load → outputs return to reset values immediately. A fresh full load then completes with `done`=1.
- `start` pulsed while busy → ignored. `start` in DONE → `cpu_run` and `done` fall on that edge and a new session begins.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Receives a length-prefixed byte stream over valid/ready, packs bytes into
// big-endian 32-bit words and writes them through a dedicated memory write
// port. The processor is held stopped until a complete, legal image is in.
module imem_loader #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_run,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] len_in;
  logic [1:0]  byte_cnt;
  logic [23:0] word_reg;
  logic        img_end;
  logic        accept;
  logic        start_take;

  assign accept     = rx_valid & rx_ready;
  assign start_take = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
  assign len_in     = {len_hi, rx_data};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          if (len_in == 16'd0)              state_nxt = S_DONE;
          else if (len_in > 16'(DEPTH))     state_nxt = S_ERR;
          else                              state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        // Leave only once the final word's write cycle has completed.
        if (img_end && im_we) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status and handshake outputs decoded from state
  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    cpu_run  = 1'b0;
    error    = 1'b0;
    unique case (state)
      S_LEN_HI, S_LEN_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DATA: begin
        rx_ready = ~img_end;
        busy     = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        cpu_run = 1'b1;
      end
      S_ERR: begin
        error = 1'b1;
      end
      default: ;
    endcase
  end

  // Length capture, byte packing and memory write strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_hi   <= '0;
      len      <= '0;
      byte_cnt <= '0;
      word_reg <= '0;
      img_end  <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      word_cnt <= '0;
    end else begin
      im_we <= 1'b0;

      if (start_take) begin
        word_cnt <= '0;
        byte_cnt <= '0;
        img_end  <= 1'b0;
      end

      if (state == S_LEN_HI && accept) begin
        len_hi <= rx_data;
      end

      if (state == S_LEN_LO && accept) begin
        len <= len_in;
      end

      if (state == S_DATA && accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          // Earlier bytes were shifted in from the bottom, so the first byte
          // of the word now sits in word_reg[23:16].
          im_we    <= 1'b1;
          im_addr  <= 32'({word_cnt, 2'b00});
          im_wdata <= {word_reg, rx_data};
          word_cnt <= word_cnt + 16'd1;
          if (word_cnt + 16'd1 == len) img_end <= 1'b1;
        end else begin
          word_reg <= {word_reg[15:0], rx_data};
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued as the
// stream is driven and matched against each im_we pulse.
module tb_imem_loader;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_run;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_cnt;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[0:63];
  int          n_tests = 0;
  int          n_fail  = 0;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_run  (cpu_run),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Match every write pulse against the oldest expected write
  always @(negedge clk) begin : monitor
    wr_t w;
    if (im_we) begin
      if (!rst) begin
        check("we_in_reset", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        check("we_unexpected", im_addr, 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", im_addr, w.addr);
        check("wr_data", im_wdata, w.data);
        check("run_during_we", 32'(cpu_run), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({pfx, "_im_we"},    32'(im_we),    32'd0);
    check({pfx, "_cpu_run"},  32'(cpu_run),  32'd0);
    check({pfx, "_busy"},     32'(busy),     32'd0);
    check({pfx, "_done"},     32'(done),     32'd0);
    check({pfx, "_error"},    32'(error),    32'd0);
    check({pfx, "_im_addr"},  im_addr,       32'd0);
    check({pfx, "_im_wdata"}, im_wdata,      32'd0);
    check({pfx, "_word_cnt"}, 32'(word_cnt), 32'd0);
  endtask

  // Offer one byte, with optional random idle cycles first, until accepted
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int tries;
    bit ok;
    tries = 0;
    ok    = 1'b0;
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!ok && tries < 64) begin
      @(negedge clk);
      ok = rx_ready;
      tick();
      tries++;
    end
    rx_valid = 1'b0;
    if (!ok) check("rx_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_load(input logic [15:0] n, input int gap_pct, input bit start_mid);
    wr_t w;
    pulse_start();
    check("st_busy",     32'(busy),     32'd1);
    check("st_done",     32'(done),     32'd0);
    check("st_cpu_run",  32'(cpu_run),  32'd0);
    check("st_error",    32'(error),    32'd0);
    check("st_word_cnt", 32'(word_cnt), 32'd0);
    send_byte(n[15:8], gap_pct);
    send_byte(n[7:0], gap_pct);
    if (n == 16'd0) begin
      check("z_done",     32'(done),     32'd1);
      check("z_cpu_run",  32'(cpu_run),  32'd1);
      check("z_rx_ready", 32'(rx_ready), 32'd0);
      check("z_word_cnt", 32'(word_cnt), 32'd0);
      return;
    end
    if (n > 16'(DEPTH)) begin
      @(negedge clk);
      check("e_error",    32'(error),    32'd1);
      check("e_cpu_run",  32'(cpu_run),  32'd0);
      check("e_rx_ready", 32'(rx_ready), 32'd0);
      check("e_busy",     32'(busy),     32'd0);
      check("e_done",     32'(done),     32'd0);
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      w.addr = 32'(i) << 2;
      w.data = img[i];
      exp_q.push_back(w);
      for (int j = 0; j < 4; j++) begin
        send_byte(img[i][8*(3-j) +: 8], gap_pct);
      end
      if (start_mid && i == 0 && n > 16'd1) begin
        tick();
        pulse_start();
        check("mid_busy",     32'(busy),     32'd1);
        check("mid_word_cnt", 32'(word_cnt), 32'd1);
      end
    end
    // Keep offering junk: it must not be consumed after the last byte.
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    @(negedge clk);
    check("last_we",       32'(im_we),    32'd1);
    check("last_done",     32'(done),     32'd0);
    check("last_cpu_run",  32'(cpu_run),  32'd0);
    check("last_rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    check("fin_done",     32'(done),     32'd1);
    check("fin_cpu_run",  32'(cpu_run),  32'd1);
    check("fin_we",       32'(im_we),    32'd0);
    check("fin_word_cnt", 32'(word_cnt), 32'(n));
    check("fin_rx_ready", 32'(rx_ready), 32'd0);
    tick();
    rx_valid = 1'b0;
    check("hold_word_cnt", 32'(word_cnt), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    wr_t w;
    rst      = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;

    // Reset with random inputs
    for (int c = 0; c < 4; c++) begin
      start    = 1'($urandom);
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      @(negedge clk);
      check_reset_vals("rst");
      tick();
    end
    start    = 1'b0;
    rx_valid = 1'b0;
    rst      = 1'b1;
    tick();

    // Two-word image, continuous then with gaps
    img[0] = 32'h2008_0005;
    img[1] = 32'hAC08_0000;
    run_load(16'd2, 0, 1'b0);
    run_load(16'd2, 40, 1'b0);

    // Empty image and oversize image
    run_load(16'd0, 0, 1'b0);
    run_load(16'h0041, 0, 1'b0);
    img[0] = 32'h1234_5678;
    run_load(16'd1, 20, 1'b0);

    // Largest legal image
    for (int i = 0; i < 64; i++) img[i] = $urandom;
    run_load(16'(DEPTH), 0, 1'b0);

    // Reset after five data bytes of a three-word image
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    w.addr = 32'd0;
    w.data = img[0];
    exp_q.push_back(w);
    for (int j = 0; j < 4; j++) send_byte(img[0][8*(3-j) +: 8], 0);
    send_byte(img[1][31:24], 0);
    rst = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    run_load(16'd3, 30, 1'b1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
